tdc_link_lock_ctrl: RTL

TDC_LINK_LOCK_CTRL -- requirements
Module: tdc_link_lock_ctrl

---
 rtl/tdc_lock_pkg.sv | 27 ++
 rtl/lock_err_window.sv | 47 ++++
 rtl/tdc_link_lock_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/tdc_lock_pkg.sv
// Shared types for the TDC link lock controller: state encoding, error-counter
// width and the wrap-safe error delta used by the window monitor.
package tdc_lock_pkg;

    localparam int ERR_W = 36;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAIL      = 3'd4
    } lock_state_e;

    typedef logic [ERR_W-1:0] err_cnt_t;

    // Per-lane differences wrap modulo 2^ERR_W; the sum keeps its carry.
    function automatic logic [ERR_W:0] err_delta(input err_cnt_t cur1, input err_cnt_t snap1,
                                                 input err_cnt_t cur0, input err_cnt_t snap0);
        err_cnt_t d1;
        err_cnt_t d0;
        d1 = cur1 - snap1;
        d0 = cur0 - snap0;
        return {1'b0, d1} + {1'b0, d0};
    endfunction

endpackage

// File: rtl/lock_err_window.sv
// Error-rate window for LOCKED: snapshots both error counters, counts a
// 2^WIN_LOG2-cycle window and flags when the window's error delta exceeds err_th.
module lock_err_window
    import tdc_lock_pkg::*;
#(
    parameter int WIN_LOG2 = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            active,
    input  err_cnt_t        cur1,
    input  err_cnt_t        cur0,
    input  logic [15:0]     err_th,
    output logic            win_end,
    output logic            err_exceed
);

    logic [WIN_LOG2-1:0] win_cnt;
    err_cnt_t            snap1;
    err_cnt_t            snap0;
    logic [ERR_W:0]      delta;

    assign delta      = err_delta(cur1, snap1, cur0, snap0);
    assign win_end    = active && (win_cnt == '1);
    assign err_exceed = win_end && (delta > (ERR_W+1)'(err_th));

    // The window counter wraps naturally, so each window end also starts the next one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_cnt <= '0;
            snap1   <= '0;
            snap0   <= '0;
        end else if (load) begin
            win_cnt <= '0;
            snap1   <= cur1;
            snap0   <= cur0;
        end else if (active) begin
            win_cnt <= win_cnt + 1'b1;
            if (win_end) begin
                snap1 <= cur1;
                snap0 <= cur0;
            end
        end
    end

endmodule

// File: rtl/tdc_link_lock_ctrl.sv
// Link bring-up controller for the TDC phase selector: reset, wait for lock,
// monitor errors, relock or fail. LOCK_CTRL_K28_ALT_EN alternates the comma on retries.
module tdc_link_lock_ctrl
    import tdc_lock_pkg::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int WIN_LOG2   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_k28_1,
    input  logic [3:0]        max_retries,
    input  logic [23:0]       lock_timeout,
    input  logic [15:0]       err_th,
    input  logic              locked_dline1,
    input  logic              locked_dline0,
    input  logic [ERR_W-1:0]  total_error_bit_dline1,
    input  logic [ERR_W-1:0]  total_error_bit_dline0,
    output logic              ps_rst,
    output logic              enable_K28_1,
    output logic              link_up,
    output logic              link_fail,
    output logic [2:0]        state,
    output logic [3:0]        retry_count,
    output logic [15:0]       relock_count
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    lock_state_e state_q, nxt;
    logic [RC_W-1:0] rst_cnt;
    logic [23:0]     wait_cnt;
    logic [3:0]      nxt_retry;
    logic [15:0]     nxt_relock;
    logic            nxt_k28;
    logic            ld_snap;
    logic            win_end;
    logic            err_exceed;
    logic            both_locked;

    assign both_locked = locked_dline1 && locked_dline0;
    assign state       = state_q;

    lock_err_window #(.WIN_LOG2(WIN_LOG2)) u_win (
        .clk        (clk),
        .rst        (rst),
        .load       (ld_snap),
        .active     (state_q == ST_LOCKED),
        .cur1       (total_error_bit_dline1),
        .cur0       (total_error_bit_dline0),
        .err_th     (err_th),
        .win_end    (win_end),
        .err_exceed (err_exceed)
    );

    always_comb begin
        nxt        = state_q;
        nxt_retry  = retry_count;
        nxt_relock = relock_count;
        nxt_k28    = enable_K28_1;
        ld_snap    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (start) begin
                    nxt       = ST_RESET;
                    nxt_retry = '0;
                    nxt_k28   = cfg_k28_1;
                end
            end
            ST_RESET: begin
                if (rst_cnt == RC_W'(RST_CYCLES - 1))
                    nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // wait_cnt is 0 in the first WAIT_LOCK cycle; lock beats a same-cycle timeout.
                if (both_locked) begin
                    nxt     = ST_LOCKED;
                    ld_snap = 1'b1;
                end else if (wait_cnt == lock_timeout) begin
                    if (retry_count == max_retries) begin
                        nxt = ST_FAIL;
                    end else begin
                        nxt       = ST_RESET;
                        nxt_retry = retry_count + 4'd1;
`ifdef LOCK_CTRL_K28_ALT_EN
                        nxt_k28   = ~enable_K28_1;
`endif
                    end
                end
            end
            ST_LOCKED: begin
                if (!both_locked || err_exceed) begin
                    nxt        = ST_RESET;
                    nxt_retry  = '0;
                    nxt_relock = (relock_count == 16'hFFFF) ? relock_count : relock_count + 16'd1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ps_rst       <= 1'b1;
            enable_K28_1 <= 1'b0;
            link_up      <= 1'b0;
            link_fail    <= 1'b0;
            retry_count  <= '0;
            relock_count <= '0;
            rst_cnt      <= '0;
            wait_cnt     <= '0;
        end else begin
            state_q      <= nxt;
            ps_rst       <= (nxt != ST_WAIT_LOCK) && (nxt != ST_LOCKED);
            enable_K28_1 <= nxt_k28;
            link_up      <= (nxt == ST_LOCKED);
            link_fail    <= (nxt == ST_FAIL);
            retry_count  <= nxt_retry;
            relock_count <= nxt_relock;
            rst_cnt      <= (state_q == ST_RESET && nxt == ST_RESET) ? rst_cnt + RC_W'(1) : '0;
            wait_cnt     <= (state_q == ST_WAIT_LOCK && nxt == ST_WAIT_LOCK) ? wait_cnt + 24'd1 : '0;
        end
    end

endmodule
